// File: rtl/ff_write_arbiter_pkg.sv
// Shared types and constants for the register write arbiter.
package ff_arb_pkg;

    // Completed-write counter width; the counter wraps modulo 2^COUNT_W.
    localparam int COUNT_W = 16;

    // Transaction sequencer: latch a winner, drive one write, check readback.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/ff_write_arbiter_rr_pick.sv
// Round-robin picker: first active request after ptr, wrapping modulo NREQ.
// The requester at ptr itself is searched last, so the last owner has the
// lowest priority but still wins when it is the only one asking.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] idx;
    logic           found;

    assign any = |req;

    // Walk ptr+1, ptr+2, ... ptr+NREQ and keep the first set request.
    always_comb begin
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
    end

endmodule

// File: rtl/ff_write_arbiter.sv
// Round-robin write arbiter in front of one enable-gated register.
// Each transaction takes three cycles: latch winner, pulse en/ready,
// compare readback. Tracks last owner, good-write count and a sticky error.
module ff_write_arbiter
    import ff_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DW-1:0]    req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  en,
    output logic [DW-1:0]         d,
    input  logic [DW-1:0]         q,
    output logic [IDW-1:0]        wr_owner,
    output logic [COUNT_W-1:0]    wr_count,
    output logic                  err,
    input  logic                  err_clr,
    output logic                  busy
);

    state_t                     state;
    state_t                     state_nx;
    logic [IDW-1:0]             ptr;
    logic [IDW-1:0]             gnt_id;
    logic                       any;
    logic [DW-1:0]              data_r;
    logic [NREQ-1:0][DW-1:0]    lane_data;
    logic                       rb_match;

    // Per-requester view of the flat data bus.
    assign lane_data = req_data;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: IDLE waits for a request, ISSUE and SETTLE last one cycle each.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any) state_nx = ISSUE;
            ISSUE:   state_nx = SETTLE;
            SETTLE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Winner and its data are captured in IDLE so later valid/data changes
    // by the requester cannot disturb the write in flight; the priority
    // pointer moves only once the write is actually issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= IDW'(NREQ - 1);
            data_r   <= '0;
            wr_owner <= '0;
        end else if (state == IDLE && any) begin
            wr_owner <= gnt_id;
            data_r   <= lane_data[gnt_id];
        end else if (state == ISSUE) begin
            ptr      <= wr_owner;
        end
    end

    assign rb_match = (q == data_r);

    // Readback check in SETTLE; a mismatch beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            err      <= 1'b0;
        end else begin
            if (state == SETTLE && rb_match)
                wr_count <= wr_count + COUNT_W'(1);
            if (state == SETTLE && !rb_match)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

    assign en   = (state == ISSUE);
    assign d    = data_r;
    assign busy = (state != IDLE);

    // One-hot ready strobe for the latched owner during ISSUE.
    for (genvar i = 0; i < NREQ; i++) begin : g_ready
        assign req_ready[i] = (state == ISSUE) && (wr_owner == IDW'(i));
    end

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Directed bench for ff_write_arbiter with a simple enable-gated register model.
module tb_ff_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              en;
    logic [DW-1:0]     d;
    logic [DW-1:0]     q = '0;
    logic [IDW-1:0]    wr_owner;
    logic [15:0]       wr_count;
    logic              err;
    logic              err_clr = 1'b0;
    logic              busy;
    logic              ignore_en = 1'b0;

    int total = 0;
    int bad   = 0;

    ff_write_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .en        (en),
        .d         (d),
        .q         (q),
        .wr_owner  (wr_owner),
        .wr_count  (wr_count),
        .err       (err),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register under test: loads d when en, unless told to ignore en.
    always @(posedge clk) begin
        if (en && !ignore_en) q <= d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b exp=0", en); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_d got=%h exp=0", d); end
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (wr_owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", wr_owner); end
        total++; if (wr_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", wr_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_data[31:0] = 32'hDEADBEEF;
        req_valid = 4'b0001;
        tick();
        total++; if (en !== 1'b1) begin bad++; $display("FAIL single_en got=%0b exp=1", en); end
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL single_d got=%h exp=deadbeef", d); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b exp=1", busy); end
        req_valid = 4'b0000;
        tick();
        total++; if (en !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("FAIL single_settle en=%0b ready=%b exp en=0 ready=0000", en, req_ready); end
        total++; if (q !== 32'hDEADBEEF) begin bad++; $display("FAIL single_q got=%h exp=deadbeef", q); end
        tick();
        total++; if (wr_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", wr_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%0b exp=0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%0b exp=0", busy); end
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL single_d_hold got=%h exp=deadbeef", d); end
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'h1111_0000 + i;
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            total++; if (req_ready !== (4'b0001 << exp_id[g]) || en !== 1'b1) begin bad++; $display("FAIL rr_grant%0d ready=%b en=%0b exp_id=%0d", g, req_ready, en, exp_id[g]); end
            total++; if (wr_owner !== IDW'(exp_id[g])) begin bad++; $display("FAIL rr_owner%0d got=%0d exp=%0d", g, wr_owner, exp_id[g]); end
            total++; if (d !== 32'h1111_0000 + exp_id[g]) begin bad++; $display("FAIL rr_data%0d got=%h exp=%h", g, d, 32'h1111_0000 + exp_id[g]); end
            if (g == 4) req_valid = 4'b0000;
            tick();
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rr_gap_a%0d got=%b exp=0000", g, req_ready); end
            tick();
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rr_gap_b%0d got=%b exp=0000", g, req_ready); end
        end
        total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL rr_count got=%0d exp=5", wr_count); end
    endtask

    task automatic test_mismatch();
        ignore_en = 1'b1;
        req_data[1*DW +: DW] = 32'hA5A5_0001;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mm_err got=%0b exp=1", err); end
        total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL mm_count got=%0d exp=5", wr_count); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mm_clr got=%0b exp=0", err); end
        // Clear held across a whole mismatching transaction: the set must win.
        err_clr = 1'b1;
        req_data[1*DW +: DW] = 32'hA5A5_0002;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mm_clr_pre got=%0b exp=0", err); end
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mm_set_wins got=%0b exp=1", err); end
        total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL mm_count2 got=%0d exp=5", wr_count); end
        tick();
        err_clr = 1'b0;
        ignore_en = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mm_final_clr got=%0b exp=0", err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4] = '{32'hC0DE_0000, 32'hC0DE_0001, 32'h0BAD_F00D, 32'h1234_5678};
        req_data[2*DW +: DW] = seq[0];
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=0100", k, req_ready); end
            total++; if (d !== seq[k]) begin bad++; $display("FAIL b2b_d%0d got=%h exp=%h", k, d, seq[k]); end
            if (k < 3) req_data[2*DW +: DW] = seq[k+1];
            else       req_valid = 4'b0000;
            tick();
            total++; if (q !== seq[k] || req_ready !== 4'b0) begin bad++; $display("FAIL b2b_q%0d got=%h ready=%b exp=%h", k, q, req_ready, seq[k]); end
            tick();
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL b2b_idle%0d got=%b exp=0000", k, req_ready); end
        end
        total++; if (wr_count !== 16'd9) begin bad++; $display("FAIL b2b_count got=%0d exp=9", wr_count); end
        total++; if (wr_owner !== 2'd2) begin bad++; $display("FAIL b2b_owner got=%0d exp=2", wr_owner); end
    endtask

    task automatic test_wrap();
        force dut.wr_count = 16'hFFFE;
        tick();
        release dut.wr_count;
        req_data[0 +: DW] = 32'h0000_FFFF;
        for (int k = 0; k < 2; k++) begin
            req_valid = 4'b0001;
            tick();
            req_valid = 4'b0000;
            tick();
            tick();
            total++; if (wr_count !== (k == 0 ? 16'hFFFF : 16'h0000)) begin bad++; $display("FAIL wrap%0d got=%h exp=%h", k, wr_count, (k == 0 ? 16'hFFFF : 16'h0000)); end
        end
    endtask

    task automatic test_reset_mid();
        req_data[3*DW +: DW] = 32'h7777_3333;
        req_valid = 4'b1000;
        tick();
        total++; if (en !== 1'b1 || req_ready !== 4'b1000) begin bad++; $display("FAIL rmid_issue en=%0b ready=%b exp en=1 ready=1000", en, req_ready); end
        rst = 1'b1;
        #1;
        total++; if (en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async en=%0b ready=%b busy=%0b exp 0", en, req_ready, busy); end
        total++; if (d !== 32'h0 || wr_owner !== 2'd0 || wr_count !== 16'h0 || err !== 1'b0) begin bad++; $display("FAIL rmid_regs d=%h owner=%0d count=%h err=%0b exp 0", d, wr_owner, wr_count, err); end
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (req_ready !== 4'b0 || wr_count !== 16'h0) begin bad++; $display("FAIL rmid_after%0d ready=%b count=%h exp 0", k, req_ready, wr_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mismatch();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
